// File: rtl/prime_input_deserializer.sv
// Assembles nbits-wide candidates from chunk_bits slices clocked in by an async pin strobe,
// then presents each completed word to the prime detector over a val/rdy handshake.
`timescale 1ns/1ps
module prime_input_deserializer #(
  parameter int nbits      = 16,
  parameter int chunk_bits = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [chunk_bits-1:0]               in_data,
  input  logic                                in_strobe,
  output logic [nbits-1:0]                    out_msg,
  output logic                                out_val,
  input  logic                                out_rdy,
  output logic                                out_ovf,
  output logic [$clog2(nbits/chunk_bits):0]   out_count
);

  // state   | meaning
  // COLLECT | shifting in slices, out_val low, out_rdy ignored
  // FULL    | complete word held on out_msg, waiting for out_rdy

  localparam int NSLICE = nbits / chunk_bits;
  localparam int CW     = $clog2(NSLICE) + 1;

  typedef enum logic {ST_COLLECT, ST_FULL} state_t;

  logic              r_rst_meta, r_rst_sync;
  logic              r_s1, r_s2, r_s3;
  state_t            r_state;
  logic [nbits-1:0]  r_msg;
  logic              r_val, r_ovf;
  logic [CW-1:0]     r_count;

  logic              w_rst_n;
  logic              w_edge;
  logic              w_xfer;
  logic [nbits-1:0]  w_shifted;
  logic [CW-1:0]     w_count_inc;

  // Reset asserts asynchronously but releases on clk so the FSM never sees a runt release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= in_strobe;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge      = r_s2 & ~r_s3;
  assign w_xfer      = r_val & out_rdy;
  assign w_shifted   = {r_msg[nbits-chunk_bits-1:0], in_data};
  assign w_count_inc = r_count + CW'(1);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_COLLECT;
      r_msg   <= '0;
      r_val   <= 1'b0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_edge) begin
            r_msg   <= w_shifted;
            r_count <= w_count_inc;
            if (w_count_inc == CW'(NSLICE)) begin
              r_state <= ST_FULL;
              r_val   <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (w_xfer) begin
            r_val   <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= ST_COLLECT;
            // A slice landing on the transfer cycle starts the next word.
            if (w_edge) begin
              r_msg   <= w_shifted;
              r_count <= CW'(1);
            end else begin
              r_count <= '0;
            end
          end else if (w_edge) begin
            r_ovf <= 1'b1;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign out_msg   = r_msg;
  assign out_val   = r_val;
  assign out_ovf   = r_ovf;
  assign out_count = r_count;

endmodule

// File: tb/tb_prime_input_deserializer.sv
// Bench for prime_input_deserializer: directed vector table, hand-built corner sequences,
// and randomized slices/out_rdy checked every cycle against a slice-arrival reference model.
`timescale 1ns/1ps
module tb_prime_input_deserializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  in_data;
  logic        in_strobe;
  logic        out_rdy;
  logic [15:0] out_msg;
  logic        out_val;
  logic        out_ovf;
  logic [2:0]  out_count;

  prime_input_deserializer #(.nbits(16), .chunk_bits(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_strobe (in_strobe),
    .out_msg   (out_msg),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a slice raised on the strobe arrives 3 clocks later (2-flop sync + edge flop).
  typedef struct {int cyc; int d;} arr_t;
  arr_t q[$];
  int   cyc = 0;
  int   m_word = 0;
  int   m_cnt = 0;
  bit   m_val = 0;
  bit   m_ovf = 0;
  bit   m_edge;
  int   m_d;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_word = 0; m_cnt = 0; m_val = 0; m_ovf = 0;
      q.delete();
    end else begin
      cyc++;
      m_edge = 0;
      m_d    = 0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        m_edge = 1;
        m_d    = q[0].d;
        void'(q.pop_front());
      end
      if (!m_val) begin
        if (m_edge) begin
          m_word = (m_word * 16 + m_d) % 65536;
          m_cnt  = m_cnt + 1;
          if (m_cnt == 4) m_val = 1;
        end
      end else if (out_rdy) begin
        m_val = 0;
        m_ovf = 0;
        if (m_edge) begin
          m_word = (m_word * 16 + m_d) % 65536;
          m_cnt  = 1;
        end else begin
          m_cnt = 0;
        end
      end else if (m_edge) begin
        m_ovf = 1;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      check("mdl_msg",   out_msg,   m_word);
      check("mdl_val",   out_val,   m_val);
      check("mdl_ovf",   out_ovf,   m_ovf);
      check("mdl_count", out_count, m_cnt);
    end
  end

  int          val_cycles;
  logic [15:0] last_msg;
  always @(negedge clk) begin
    if (out_val) begin
      val_cycles++;
      last_msg = out_msg;
    end
  end

  bit rnd_rdy = 0;

  task automatic tick();
    @(negedge clk);
    if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [3:0] d, input int hold);
    tick();
    in_data   = d;
    in_strobe = 1'b1;
    q.push_back('{cyc + 3, int'(d)});
    repeat (hold) tick();
    in_strobe = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send4(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*4 +: 4], 3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {logic [15:0] slices; logic [15:0] exp;} vec_t;
  vec_t vt[4];

  initial begin
    vt[0] = '{16'hABCD, 16'hABCD};
    vt[1] = '{16'hF0F0, 16'hF0F0};
    vt[2] = '{16'h9876, 16'h9876};
    vt[3] = '{16'h0001, 16'h0001};

    reset_n = 1'b0; in_strobe = 1'b0; in_data = 4'h0; out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_msg",   out_msg,   16'h0);
    check("rst_val",   out_val,   1'b0);
    check("rst_ovf",   out_ovf,   1'b0);
    check("rst_count", out_count, 3'd0);
    release_reset();
    chk_en = 1;

    // 1: rdy high, out_val pulses once with 0x0013
    out_rdy = 1'b1;
    val_cycles = 0; last_msg = 16'h0;
    send4(16'h0013);
    repeat (3) @(negedge clk);
    check("t1_val_pulse", val_cycles, 1);
    check("t1_msg",       last_msg,   16'h0013);
    check("t1_count",     out_count,  3'd0);
    out_rdy = 1'b0;

    // 2: table, word held 20 cycles then one-cycle transfer
    for (int v = 0; v < 4; v++) begin
      send4(vt[v].slices);
      repeat (20) @(negedge clk);
      check("t2_val_held", out_val,   1'b1);
      check("t2_msg_held", out_msg,   vt[v].exp);
      check("t2_count",    out_count, 3'd4);
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      check("t2_xfer_val",   out_val,   1'b0);
      check("t2_xfer_count", out_count, 3'd0);
    end

    // 3: overflow while held, cleared by transfer
    send4(16'h2468);
    send(4'h7, 3);
    check("t3_ovf",   out_ovf, 1'b1);
    check("t3_msg",   out_msg, 16'h2468);
    check("t3_val",   out_val, 1'b1);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    check("t3_ovf_clr", out_ovf, 1'b0);

    // 4: slice lands on the transfer cycle
    send4(16'h1234);
    @(negedge clk);
    in_data = 4'h5; in_strobe = 1'b1;
    q.push_back('{cyc + 3, 5});
    @(negedge clk);
    @(negedge clk);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    check("t4_count1", out_count, 3'd1);
    check("t4_val",    out_val,   1'b0);
    check("t4_ovf",    out_ovf,   1'b0);
    in_strobe = 1'b0;
    repeat (3) @(negedge clk);
    send(4'h0, 3); send(4'h0, 3); send(4'h0, 3);
    check("t4_val_full", out_val, 1'b1);
    check("t4_msg",      out_msg, 16'h5000);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;

    // 5: mid-word reset, then a fresh word, then reset while FULL
    send(4'h8, 3); send(4'h9, 3);
    check("t5_partial", out_count, 3'd2);
    do_reset();
    check("t5_rst_msg",   out_msg,   16'h0);
    check("t5_rst_val",   out_val,   1'b0);
    check("t5_rst_count", out_count, 3'd0);
    release_reset();
    send4(16'h1234);
    check("t5_msg", out_msg, 16'h1234);
    check("t5_val", out_val, 1'b1);
    do_reset();
    check("t5_full_rst_val", out_val, 1'b0);
    check("t5_full_rst_msg", out_msg, 16'h0);
    release_reset();

    // 6: strobe held high counts once
    send(4'h9, 50);
    check("t6_count", out_count, 3'd1);
    check("t6_val",   out_val,   1'b0);
    do_reset();
    release_reset();

    // randomized slices with random out_rdy, checked by the model each cycle
    rnd_rdy = 1;
    for (int n = 0; n < 60; n++) send(4'($urandom_range(0, 15)), $urandom_range(1, 5));
    rnd_rdy = 0;
    out_rdy = 1'b1;
    repeat (5) @(negedge clk);
    check("rnd_drain_val", out_val, 1'b0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
